max7219_rx: RTL

Receive-side model of the MAX7219 serial protocol. Samples a 3-wire stream (CLK/DIN/LOAD) produced by a MAX7219 master and decodes each 16-bit command into a shadow copy of the chip's register file. Used on-chip to mirror display content onto debug logic or a second display, and as the self-checking monitor for the display driver in simulation.

---
 rtl/max7219_rx.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/max7219_rx.sv
// MAX7219 receive-side decoder: samples CLK/DIN/LOAD from a master and
// mirrors each accepted 16-bit command into a shadow register file.
//
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   sclk_in, din_in   serial clock / data from master (async, MSB first)
//   load_in           LOAD/CS (async); low while shifting, rise latches
//   digits_out        digit registers, [8k+7:8k] = digit k (addr k+1)
//   decode_mode       reg 0x9
//   intensity         reg 0xA [3:0]
//   scan_limit        reg 0xB [2:0]
//   shutdown_n        reg 0xC bit 0 (0 = shutdown)
//   display_test      reg 0xF bit 0
//   wr_strobe         one-cycle pulse per accepted frame
//   wr_addr, wr_data  address / data of last accepted frame
//   frame_err         one-cycle pulse when LOAD rises on a short frame
//
// Optional build macro MAX7219_RX_HEXDEC_EN adds hex_out[31:0] and
// hex_bad[7:0]: per-digit inverse seven-segment decode of digits_out.

module max7219_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sclk_in,
  input  logic        din_in,
  input  logic        load_in,
  output logic [63:0] digits_out,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic        wr_strobe,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_err
`ifdef MAX7219_RX_HEXDEC_EN
  ,
  output logic [31:0] hex_out,
  output logic [7:0]  hex_bad
`endif
);

  if (SYNC_STAGES < 2 || FRAME_BITS != 16) begin : g_bad_param
    $error("max7219_rx: SYNC_STAGES>=2 and FRAME_BITS==16 required");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;

  logic sclk_prev_q, sclk_prev_d;
  logic load_prev_q, load_prev_d;

  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [63:0] digits_q, digits_d;
  logic [7:0]  decode_q, decode_d;
  logic [3:0]  inten_q, inten_d;
  logic [2:0]  scan_q, scan_d;
  logic        shdn_q, shdn_d;
  logic        test_q, test_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;

  logic sclk_s, din_s, load_s;
  logic sclk_rise, load_rise, load_fall;
  logic [3:0] f_addr;
  logic [7:0] f_data;
  logic       frame_ok;

  // Upper nibble of the frame is a don't-care on the real chip.
  logic unused_hi;
  assign unused_hi = ^shreg_q[15:12];

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];
  assign load_s = load_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign load_rise = load_s & ~load_prev_q;
  assign load_fall = ~load_s & load_prev_q;

  assign f_addr   = shreg_q[11:8];
  assign f_data   = shreg_q[7:0];
  assign frame_ok = (cnt_q >= 5'(FRAME_BITS));

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din_in};
    load_sync_d = {load_sync_q[SYNC_STAGES-2:0], load_in};
    sclk_prev_d = sclk_s;
    load_prev_d = load_s;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    decode_d    = decode_q;
    inten_d     = inten_q;
    scan_d      = scan_q;
    shdn_d      = shdn_q;
    test_d      = test_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_fall) begin
          state_d = ST_SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // A coincident load rise still takes this last bit.
        if (sclk_rise) begin
          shreg_d = {shreg_q[14:0], din_s};
          if (cnt_q != 5'd31) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        if (load_rise) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (frame_ok) begin
          wr_strobe_d = 1'b1;
          wr_addr_d   = f_addr;
          wr_data_d   = f_data;
          case (f_addr)
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: begin
              digits_d[{f_addr - 4'd1, 3'b000} +: 8] = f_data;
            end
            4'h9: decode_d = f_data;
            4'hA: inten_d  = f_data[3:0];
            4'hB: scan_d   = f_data[2:0];
            4'hC: shdn_d   = f_data[0];
            4'hF: test_d   = f_data[0];
            default: ;
          endcase
        end else begin
          frame_err_d = 1'b1;
        end
        // Allow a new frame to start immediately.
        if (load_fall) begin
          state_d = ST_SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      load_sync_q <= '1;
      sclk_prev_q <= 1'b0;
      load_prev_q <= 1'b1;
      shreg_q     <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      decode_q    <= '0;
      inten_q     <= '0;
      scan_q      <= '0;
      shdn_q      <= 1'b0;
      test_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      din_sync_q  <= din_sync_d;
      load_sync_q <= load_sync_d;
      sclk_prev_q <= sclk_prev_d;
      load_prev_q <= load_prev_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      decode_q    <= decode_d;
      inten_q     <= inten_d;
      scan_q      <= scan_d;
      shdn_q      <= shdn_d;
      test_q      <= test_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(wr_strobe_q && frame_err_q))
        else $error("strobe and frame_err together");
    end
  end

  assign digits_out   = digits_q;
  assign decode_mode  = decode_q;
  assign intensity    = inten_q;
  assign scan_limit   = scan_q;
  assign shutdown_n   = shdn_q;
  assign display_test = test_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_err    = frame_err_q;

`ifdef MAX7219_RX_HEXDEC_EN
  // {bad, nibble}; DP bit is excluded by the caller.
  function automatic logic [4:0] seg2hex(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h7D:   r = 5'h0A;
      7'h1F:   r = 5'h0B;
      7'h0D:   r = 5'h0C;
      7'h3D:   r = 5'h0D;
      7'h4F:   r = 5'h0E;
      7'h47:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < 8; k++) begin : g_hex
    assign {hex_bad[k], hex_out[4*k +: 4]} = seg2hex(digits_q[8*k +: 7]);
  end
`endif

endmodule
